// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC generation, SRAM-like instruction port and the
// fs->ds handshake, with stale-read discarding after redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int unsigned FS_TO_DS_W = 65
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ds_allowin,
    output logic                  fs_to_ds_valid,
    output logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
    input  logic [32:0]           br_bus,
    input  logic                  wb_ex,
    input  logic [31:0]           csr_eentry,
    input  logic                  wb_ertn,
    input  logic [31:0]           csr_era,
    output logic                  inst_sram_req,
    output logic                  inst_sram_wr,
    output logic [1:0]            inst_sram_size,
    output logic [3:0]            inst_sram_wstrb,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic                  inst_sram_addr_ok,
    input  logic                  inst_sram_data_ok,
    input  logic [31:0]           inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             fetch_pc_q, fetch_pc_d;
    logic [31:0]             redir_pc_q, redir_pc_d;
    logic                    redir_pending_q, redir_pending_d;
    logic                    drop_q, drop_d;
    logic                    valid_q, valid_d;
    logic [FS_TO_DS_W-1:0]   bus_q, bus_d;

    logic                    br_taken;
    logic [31:0]             br_target;
    logic                    redir;
    logic [31:0]             redir_tgt;
    logic [31:0]             issue_pc;

    assign {br_taken, br_target} = br_bus;

    always_comb begin
        redir = wb_ex | wb_ertn | br_taken;
        if (wb_ex)
            redir_tgt = csr_eentry;
        else if (wb_ertn)
            redir_tgt = csr_era;
        else
            redir_tgt = br_target;
        // A live redirect beats a parked one, which beats the sequential PC.
        if (redir)
            issue_pc = redir_tgt;
        else if (redir_pending_q)
            issue_pc = redir_pc_q;
        else
            issue_pc = fetch_pc_q;
    end

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        redir_pc_d      = redir_pc_q;
        redir_pending_d = redir_pending_q;
        drop_d          = drop_q;
        valid_d         = valid_q;
        bus_d           = bus_q;

        if (redir) begin
            valid_d = 1'b0;
            bus_d   = '0;
            if (state_q != S_IDLE) begin
                redir_pc_d      = redir_tgt;
                redir_pending_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                fetch_pc_d      = issue_pc;
                redir_pending_d = 1'b0;
                if (issue_pc[1:0] != 2'b00) begin
                    valid_d = 1'b1;
                    bus_d   = {1'b1, 32'h0, issue_pc};
                    state_d = S_HOLD;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Request stays pinned to fetch_pc; a redirect only marks it stale.
                if (redir)
                    drop_d = 1'b1;
                if (inst_sram_addr_ok)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (drop_q || redir) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        valid_d    = 1'b1;
                        bus_d      = {1'b0, inst_sram_rdata, fetch_pc_q};
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    state_d = S_IDLE;
                end else if (ds_allowin) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (bus_q[FS_TO_DS_W-1])
                        fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            fetch_pc_q      <= RESET_PC;
            redir_pc_q      <= '0;
            redir_pending_q <= 1'b0;
            drop_q          <= 1'b0;
            valid_q         <= 1'b0;
            bus_q           <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            redir_pc_q      <= redir_pc_d;
            redir_pending_q <= redir_pending_d;
            drop_q          <= drop_d;
            valid_q         <= valid_d;
            bus_q           <= bus_d;
        end
    end

    assign fs_to_ds_valid  = valid_q;
    assign fs_to_ds_bus    = bus_q;
    assign inst_sram_req   = (state_q == S_REQ);
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = '0;
    assign inst_sram_wdata = '0;

endmodule
